// File: rtl/sp1_hmem_ctrl.sv
// rtl/sp1_hmem_ctrl.sv - burst controller splitting word commands into even/odd heap bank beats
// Optional: SP1_HMEM_CTRL_BOUND_CHK_EN rejects commands that would run past the end of the heap.
module sp1_hmem_ctrl #(
  parameter int DW         = 32,
  parameter int HEAP_ABITS = 16,
  parameter int WORD_ABITS = 2,
  parameter int LW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_req,
  output logic          cmd_ack,
  input  logic          cmd_we,
  input  logic [DW-1:0] cmd_adrs,
  input  logic [LW-1:0] cmd_len,
  output logic          cmd_done,
  output logic          cmd_err,
  output logic          wd_ack,
  input  logic [DW-1:0] wr_dt0,
  input  logic [DW-1:0] wr_dt1,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dt0,
  output logic [DW-1:0] rd_dt1,
  output logic          cs_ev,
  output logic          cs_od,
  output logic          we_ev,
  output logic          we_od,
  output logic [DW-1:0] adrs_ev,
  output logic [DW-1:0] adrs_od,
  output logic [DW-1:0] wr_dt_ev,
  output logic [DW-1:0] wr_dt_od,
  input  logic [DW-1:0] rd_dt_ev,
  input  logic [DW-1:0] rd_dt_od
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HEAP_ABITS-1:0] WBYTES = HEAP_ABITS'(1) << WORD_ABITS;

  state_t                       state_q, state_d;
  logic                         we_q, we_d;
  logic [DW-HEAP_ABITS-1:0]     hi_q, hi_d;
  logic [HEAP_ABITS-1:0]        off_q, off_d;
  logic [LW-1:0]                rem_q, rem_d;
  logic                         odd_q, odd_d;
  logic                         phase_q, phase_d;
  logic                         ack_q, ack_d;
  logic                         wdack_q, wdack_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         p1_vld_q, p1_vld_d;
  logic                         p1_phase_q, p1_phase_d;
  logic                         p1_lodd_q, p1_lodd_d;
  logic                         p1_last_q, p1_last_d;
  logic                         rvld_q, rvld_d;
  logic [DW-1:0]                rdt0_q, rdt0_d;
  logic [DW-1:0]                rdt1_q, rdt1_d;

  logic          busy, last, lodd, oob;
  logic [DW-1:0] a0, a1;
  logic [LW-1:0] beats;
  logic          unused_lsb;

  assign busy  = (state_q == BUSY);
  assign last  = (rem_q == LW'(1));
  assign lodd  = odd_q & last;
  assign a0    = {hi_q, off_q};
  assign a1    = {hi_q, off_q + WBYTES};
  assign beats = LW'((32'(cmd_len) + 32'd1) >> 1);
  assign unused_lsb = ^cmd_adrs[WORD_ABITS-1:0];

`ifdef SP1_HMEM_CTRL_BOUND_CHK_EN
  logic [HEAP_ABITS:0] span;
  assign span = {1'b0, cmd_adrs[HEAP_ABITS-1:0]} + ((HEAP_ABITS+1)'(cmd_len) << WORD_ABITS);
  assign oob  = (span > {1'b1, {HEAP_ABITS{1'b0}}});
`else
  assign oob  = 1'b0;
`endif

  // Phase 1 means the start word lives in the odd bank, so word0/word1 swap banks.
  always_comb begin
    cs_ev    = 1'b0;
    cs_od    = 1'b0;
    adrs_ev  = '0;
    adrs_od  = '0;
    wr_dt_ev = '0;
    wr_dt_od = '0;
    if (busy) begin
      cs_ev   = ~phase_q | ~lodd;
      cs_od   =  phase_q | ~lodd;
      adrs_ev = phase_q ? a1 : a0;
      adrs_od = phase_q ? a0 : a1;
      if (we_q) begin
        wr_dt_ev = phase_q ? wr_dt1 : wr_dt0;
        wr_dt_od = phase_q ? wr_dt0 : wr_dt1;
      end
    end
    we_ev = cs_ev & we_q;
    we_od = cs_od & we_q;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    hi_d       = hi_q;
    off_d      = off_q;
    rem_d      = rem_q;
    odd_d      = odd_q;
    phase_d    = phase_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    p1_vld_d   = busy & ~we_q;
    p1_phase_d = phase_q;
    p1_lodd_d  = lodd;
    p1_last_d  = last;
    rvld_d     = p1_vld_q;
    rdt0_d     = rdt0_q;
    rdt1_d     = rdt1_q;
    // Bank data arrives one cycle after the beat; un-swap it into request order.
    if (p1_vld_q) begin
      rdt0_d = p1_phase_q ? rd_dt_od : rd_dt_ev;
      rdt1_d = p1_lodd_q ? '0 : (p1_phase_q ? rd_dt_ev : rd_dt_od);
      done_d = p1_last_q;
    end
    case (state_q)
      IDLE: begin
        if (cmd_req) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (oob) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = BUSY;
            we_d    = cmd_we;
            hi_d    = cmd_adrs[DW-1:HEAP_ABITS];
            off_d   = {cmd_adrs[HEAP_ABITS-1:WORD_ABITS], {WORD_ABITS{1'b0}}};
            rem_d   = beats;
            odd_d   = cmd_len[0];
            phase_d = cmd_adrs[WORD_ABITS];
          end
        end
      end
      BUSY: begin
        off_d = off_q + (WBYTES << 1);
        rem_d = rem_q - LW'(1);
        if (last) begin
          state_d = IDLE;
          if (we_q) done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d   = (state_d == IDLE);
    wdack_d = (state_d == BUSY) & we_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      hi_q       <= '0;
      off_q      <= '0;
      rem_q      <= '0;
      odd_q      <= 1'b0;
      phase_q    <= 1'b0;
      ack_q      <= 1'b1;
      wdack_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_phase_q <= 1'b0;
      p1_lodd_q  <= 1'b0;
      p1_last_q  <= 1'b0;
      rvld_q     <= 1'b0;
      rdt0_q     <= '0;
      rdt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      hi_q       <= hi_d;
      off_q      <= off_d;
      rem_q      <= rem_d;
      odd_q      <= odd_d;
      phase_q    <= phase_d;
      ack_q      <= ack_d;
      wdack_q    <= wdack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      p1_vld_q   <= p1_vld_d;
      p1_phase_q <= p1_phase_d;
      p1_lodd_q  <= p1_lodd_d;
      p1_last_q  <= p1_last_d;
      rvld_q     <= rvld_d;
      rdt0_q     <= rdt0_d;
      rdt1_q     <= rdt1_d;
    end
  end

  assign cmd_ack  = ack_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;
  assign wd_ack   = wdack_q;
  assign rd_vld   = rvld_q;
  assign rd_dt0   = rdt0_q;
  assign rd_dt1   = rdt1_q;

endmodule

// File: tb/tb_sp1_hmem_ctrl.sv
// tb/tb_sp1_hmem_ctrl.sv - self-checking bench for sp1_hmem_ctrl with a word-level scoreboard
`timescale 1ns/1ps
module tb_sp1_hmem_ctrl;

  localparam int MAXC = 1024;
`ifdef SP1_HMEM_CTRL_BOUND_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_req = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adrs = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wr_dt0 = '0, wr_dt1 = '0;
  logic        cmd_ack, cmd_done, cmd_err, wd_ack, rd_vld;
  logic [31:0] rd_dt0, rd_dt1;
  logic        cs_ev, cs_od, we_ev, we_od;
  logic [31:0] adrs_ev, adrs_od, wr_dt_ev, wr_dt_od;
  logic [31:0] rd_dt_ev = '0, rd_dt_od = '0;

  sp1_hmem_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_we(cmd_we), .cmd_adrs(cmd_adrs), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .wd_ack(wd_ack),
    .wr_dt0(wr_dt0), .wr_dt1(wr_dt1), .rd_vld(rd_vld), .rd_dt0(rd_dt0), .rd_dt1(rd_dt1),
    .cs_ev(cs_ev), .cs_od(cs_od), .we_ev(we_ev), .we_od(we_od),
    .adrs_ev(adrs_ev), .adrs_od(adrs_od), .wr_dt_ev(wr_dt_ev), .wr_dt_od(wr_dt_od),
    .rd_dt_ev(rd_dt_ev), .rd_dt_od(rd_dt_od)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int acc = -1;
  bit preload_req = 1'b0;
  logic [31:0] wwords [16];

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A_0000 | 32'(i);
  endfunction

  // Bank memory: data valid the cycle after cs, garbage otherwise.
  logic [31:0] mem [16384];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] = pat(i);
      mem_ready = 1'b1;
    end
    if (preload_req) for (int i = 0; i < 16; i++) mem[64+i] = 32'hA0 + 32'(i);
    rd_dt_ev <= 32'hBAD0_0E0E;
    rd_dt_od <= 32'hBAD0_0D0D;
    if (cs_ev) begin
      if (we_ev) mem[adrs_ev[15:2]] = wr_dt_ev;
      else       rd_dt_ev <= mem[adrs_ev[15:2]];
    end
    if (cs_od) begin
      if (we_od) mem[adrs_od[15:2]] = wr_dt_od;
      else       rd_dt_od <= mem[adrs_od[15:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: expected outputs per absolute cycle, derived word by word.
  logic [31:0] refmem [16384];
  bit ref_ready = 1'b0;
  bit          e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_vld[MAXC], e_wdack[MAXC];
  bit          e_cs_ev[MAXC], e_cs_od[MAXC], e_we_ev[MAXC], e_we_od[MAXC];
  logic [31:0] e_a_ev[MAXC], e_a_od[MAXC], e_w_ev[MAXC], e_w_od[MAXC], e_r0[MAXC], e_r1[MAXC];
  bit          h_cs_ev[MAXC], h_cs_od[MAXC], h_done[MAXC], h_err[MAXC], h_vld[MAXC];
  logic [31:0] h_a_ev[MAXC], h_a_od[MAXC], h_r0[MAXC], h_r1[MAXC];

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_vld[i] = 0; e_wdack[i] = 0;
      e_cs_ev[i] = 0; e_cs_od[i] = 0; e_we_ev[i] = 0; e_we_od[i] = 0;
      e_a_ev[i] = '0; e_a_od[i] = '0; e_w_ev[i] = '0; e_w_od[i] = '0; e_r0[i] = '0; e_r1[i] = '0;
    end
  endtask

  task automatic schedule(input int c, input bit we, input logic [31:0] adrs, input int len);
    int b, t;
    logic [31:0] a;
    b = (len + 1) / 2;
    if (len == 0) begin
      e_done[c+1] = 1;
    end else if (BCHK && ((adrs & 32'hFFFF) + 32'(len) * 4 > 32'h1_0000)) begin
      e_done[c+1] = 1;
      e_err[c+1]  = 1;
    end else begin
      for (int k = 0; k < b; k++) begin
        e_busy[c+1+k]  = 1;
        e_wdack[c+1+k] = we;
      end
      for (int i = 0; i < len; i++) begin
        a = (adrs & 32'hFFFF_0000) | (((adrs & 32'hFFFF_FFFC) + 32'(4 * i)) & 32'h0000_FFFF);
        t = c + 1 + i / 2;
        if (a[2]) begin
          e_cs_od[t] = 1; e_a_od[t] = a; e_we_od[t] = we; e_w_od[t] = wwords[i];
        end else begin
          e_cs_ev[t] = 1; e_a_ev[t] = a; e_we_ev[t] = we; e_w_ev[t] = wwords[i];
        end
        if (we) refmem[a[15:2]] = wwords[i];
        else begin
          e_vld[t+2] = 1;
          if (i % 2 == 0) e_r0[t+2] = refmem[a[15:2]];
          else            e_r1[t+2] = refmem[a[15:2]];
        end
      end
      e_done[we ? c + 1 + b : c + 2 + b] = 1;
    end
  endtask

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (!ref_ready) begin
      for (int i = 0; i < 16384; i++) refmem[i] = pat(i);
      clear_from(0);
      ref_ready = 1'b1;
    end
    if (preload_req) for (int i = 0; i < 16; i++) refmem[64+i] = 32'hA0 + 32'(i);
    if (c < MAXC - 16) begin
      h_cs_ev[c] = cs_ev; h_cs_od[c] = cs_od; h_done[c] = cmd_done; h_err[c] = cmd_err;
      h_vld[c] = rd_vld; h_a_ev[c] = adrs_ev; h_a_od[c] = adrs_od; h_r0[c] = rd_dt0; h_r1[c] = rd_dt1;
      if (rst) begin
        clear_from(c);
        chk("rst_ack", 32'(cmd_ack), 1);
        chk("rst_ctl", {24'd0, cmd_done, cmd_err, wd_ack, rd_vld, cs_ev, cs_od, we_ev, we_od}, 0);
        chk("rst_data", adrs_ev | adrs_od | wr_dt_ev | wr_dt_od | rd_dt0 | rd_dt1, 0);
      end else begin
        chk("ack", 32'(cmd_ack), 32'(!e_busy[c]));
        chk("done", 32'(cmd_done), 32'(e_done[c]));
        chk("err", 32'(cmd_err), 32'(e_err[c]));
        chk("wd_ack", 32'(wd_ack), 32'(e_wdack[c]));
        chk("cs", {30'd0, cs_ev, cs_od}, {30'd0, e_cs_ev[c], e_cs_od[c]});
        chk("we", {30'd0, we_ev, we_od}, {30'd0, e_we_ev[c], e_we_od[c]});
        chk("rd_vld", 32'(rd_vld), 32'(e_vld[c]));
        if (e_cs_ev[c]) chk("adrs_ev", adrs_ev, e_a_ev[c]);
        if (e_cs_od[c]) chk("adrs_od", adrs_od, e_a_od[c]);
        if (e_we_ev[c]) chk("wr_dt_ev", wr_dt_ev, e_w_ev[c]);
        if (e_we_od[c]) chk("wr_dt_od", wr_dt_od, e_w_od[c]);
        if (e_vld[c]) begin
          chk("rd_dt0", rd_dt0, e_r0[c]);
          chk("rd_dt1", rd_dt1, e_r1[c]);
        end
        if (cmd_req && cmd_ack) schedule(c, cmd_we, cmd_adrs, int'(cmd_len));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns in the first cycle a follow-on command could be accepted.
  task automatic issue(input bit we, input logic [31:0] adrs, input int len);
    int n = 0;
    cmd_req = 1'b1; cmd_we = we; cmd_adrs = adrs; cmd_len = 4'(len);
    acc = -1;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (cmd_ack) acc = cyc;
      else begin
        tick();
        n++;
      end
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout cyc=%0d act=no_ack exp=ack", cyc);
    end
    tick();
    cmd_req = 1'b0;
    if (we && acc >= 0) begin
      for (int k = 0; k < (len + 1) / 2; k++) begin
        wr_dt0 = wwords[2*k];
        wr_dt1 = (2*k + 1 < len) ? wwords[2*k+1] : 32'hDEAD_BEEF;
        tick();
      end
    end
  endtask

  initial begin
    int a, b, nv;
    for (int i = 0; i < 16; i++) wwords[i] = 32'h7700_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_ack", 32'(cmd_ack), 1);
    chk("lit_reset_vld", {30'd0, rd_vld, cmd_done}, 0);
    tick();

    wwords[0] = 32'h1111_0001; wwords[1] = 32'h2222_0002; wwords[2] = 32'h3333_0003;
    issue(1'b1, 32'h0000_0104, 3);
    a = acc;
    repeat (4) tick();
    chk("lit_w3_cs_c1", {30'd0, h_cs_ev[a+1], h_cs_od[a+1]}, 32'h3);
    chk("lit_w3_adod_c1", h_a_od[a+1], 32'h0104);
    chk("lit_w3_adev_c1", h_a_ev[a+1], 32'h0108);
    chk("lit_w3_cs_c2", {30'd0, h_cs_ev[a+2], h_cs_od[a+2]}, 32'h1);
    chk("lit_w3_adod_c2", h_a_od[a+2], 32'h010C);
    chk("lit_w3_done", 32'(h_done[a+3]), 1);
    chk("lit_w3_mem", mem[67], 32'h3333_0003);
    chk("lit_w3_untouched", mem[68], 32'h5A5A_0044);

    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
    issue(1'b0, 32'h0000_0100, 4);
    a = acc;
    issue(1'b0, 32'h0000_0104, 3);
    b = acc;
    repeat (8) tick();
    chk("lit_r4_b0", {h_r0[a+3][15:0], h_r1[a+3][15:0]}, 32'h00A0_00A1);
    chk("lit_r4_b1", {h_r0[a+4][15:0], h_r1[a+4][15:0]}, 32'h00A2_00A3);
    chk("lit_r4_done", {30'd0, h_done[a+3], h_done[a+4]}, 32'h1);
    chk("lit_r3_acc", 32'(b), 32'(a + 3));
    chk("lit_r3_b0", {h_r0[b+3][15:0], h_r1[b+3][15:0]}, 32'h00A1_00A2);
    chk("lit_r3_b1", {h_r0[b+4][15:0], h_r1[b+4][15:0]}, 32'h00A3_0000);
    chk("lit_r3_vld", {30'd0, h_vld[b+3], h_vld[b+4]}, 32'h3);

    issue(1'b0, 32'h0000_FFFC, 2);
    a = acc;
    repeat (6) tick();
`ifdef SP1_HMEM_CTRL_BOUND_CHK_EN
    chk("lit_oob_cs", {30'd0, h_cs_ev[a+1], h_cs_od[a+1]}, 0);
    chk("lit_oob_done_err", {30'd0, h_done[a+1], h_err[a+1]}, 32'h3);
`else
    chk("lit_wrap_adod", h_a_od[a+1], 32'h0000_FFFC);
    chk("lit_wrap_adev", h_a_ev[a+1], 32'h0000_0000);
    chk("lit_wrap_rd", h_r1[a+3], 32'h5A5A_0000);
`endif

    wwords[0] = 32'hCAFE_0000; wwords[1] = 32'hCAFE_0001;
    issue(1'b1, 32'h0000_0200, 0);
    a = acc;
    issue(1'b1, 32'h0000_0200, 2);
    b = acc;
    repeat (4) tick();
    chk("lit_len0_done", 32'(h_done[a+1]), 1);
    chk("lit_len0_nocs", {30'd0, h_cs_ev[a+1], h_cs_od[a+1]}, 0);
    chk("lit_b2b_acc", 32'(b), 32'(a + 1));
    chk("lit_b2b_beat", {30'd0, h_cs_ev[a+2], h_cs_od[a+2]}, 32'h3);
    chk("lit_b2b_mem", mem[129], 32'hCAFE_0001);

    issue(1'b0, 32'h0000_0100, 6);
    a = acc;
    tick();
    rst = 1'b1;
    #1;
    chk("lit_rst_mid_cs", {30'd0, cs_ev, cs_od}, 0);
    chk("lit_rst_mid_ack", 32'(cmd_ack), 1);
    chk("lit_rst_mid_adrs", adrs_ev | adrs_od, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    nv = 0;
    for (int c = a + 3; c < a + 12; c++) nv += int'(h_vld[c]);
    chk("lit_rst_no_vld", 32'(nv), 0);
    chk("lit_rst_ack_after", 32'(cmd_ack), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sp1_hmem_ctrl.md
# sp1_hmem_ctrl

Burst access controller that sits directly upstream of the dual-word heap memory. It turns a word-addressed, possibly unaligned, multi-word read or write command into one even-bank/odd-bank beat per cycle, steering word 0/word 1 to the correct bank and swapping read data back into request order. It is the single heap port seen by the STG machine's load/store/allocation logic.

## Interface
- DW, 32, data/address width (`SP1_WORD_WIDTH`)
- HEAP_ABITS, 16, heap byte-address bits (`SP1_HEAP_ABITS`)
- WORD_ABITS, 2, byte-in-word address bits (`SP1_WORD_ABITS`)
- LW, 4, command length width; length 0..2^LW-1 words
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- cmd_req  in  1  command request
- cmd_ack  out  1  command accepted when cmd_req&cmd_ack
- cmd_we  in  1  1=write, 0=read
- cmd_adrs  in  DW  start byte address (low WORD_ABITS ignored)
- cmd_len  in  LW  words to transfer
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle, coincident with cmd_done (bound check only)
- wd_ack  out  1  write beat consumed this cycle
- wr_dt0, wr_dt1  in  DW each  write words 2k, 2k+1 of beat k
- rd_vld  out  1  read beat valid
- rd_dt0, rd_dt1  out  DW each  read words 2k, 2k+1 in request order
- cs_ev, cs_od, we_ev, we_od  out  1 each  bank controls
- adrs_ev, adrs_od  out  DW each  bank byte addresses
- wr_dt_ev, wr_dt_od  out  DW each  bank write data
- rd_dt_ev, rd_dt_od  in  DW each  bank read data, valid one cycle after cs

## Operation
- States IDLE, BUSY. cmd_ack = (state==IDLE).
- Accept: latch we, address, beats B = ceil(len/2), odd = len[0], phase = cmd_adrs[WORD_ABITS]. len=0: stay IDLE, cmd_done next cycle, no bank access.
- BUSY beat k (k=0..B-1): word index w = 2k from start. Word0 byte address a0 = start + 2k·2^WORD_ABITS, a1 = a0 + 2^WORD_ABITS; sums modulo 2^HEAP_ABITS, bits above HEAP_ABITS copied from cmd_adrs, low WORD_ABITS forced 0.
- phase 0: word0→ev (adrs_ev=a0), word1→od (adrs_od=a1). phase 1: word0→od (adrs_od=a0), word1→ev (adrs_ev=a1).
- Last beat with odd=1: only word0's bank selected; other cs low.
- Write: we_* = cs_*; wr_dt_* = swapped wr_dt0/1; wd_ack high each BUSY cycle; upstream must hold valid data whenever wd_ack (no stall).
- Read: phase and last-beat-odd delayed one cycle; bank data swapped into registers rd_dt0/rd_dt1; unused word of odd last beat reads 0.
- BUSY→IDLE after beat B-1 issued; next command accepted while reads drain.
- Bank control outputs are combinational from state registers (and wr_dt0/1); all other outputs registered.

## Timing
- Reset: state IDLE; cmd_ack=1; cmd_done, cmd_err, wd_ack, rd_vld, cs_*, we_*=0; adrs_*, wr_dt_*, rd_dt0/1=0. In-flight read returns discarded.
- Accept in cycle 0; beat k on bank ports and wd_ack in cycle 1+k; bank data in cycle 2+k; rd_vld/rd_dt in cycle 3+k.
- Write cmd_done in cycle B+1; read cmd_done coincident with last rd_vld (cycle B+2).
- Back-to-back: next cmd_ack in cycle B+1; throughput one beat (two words) per cycle.
- No backpressure on rd_vld; consumer must take every beat.

## Configuration
- SP1_HMEM_CTRL_BOUND_CHK_EN defined: at accept, if (cmd_adrs mod 2^HEAP_ABITS) + len·2^WORD_ABITS > 2^HEAP_ABITS, no beats issued, cmd_done and cmd_err pulse in cycle 1, state stays IDLE.
- Not defined: cmd_err tied 0; addresses wrap modulo heap size.

## Test plan
- Reset mid-read-burst (len 6) in cycle 2 -> all outputs reset values immediately; no rd_vld after release; cmd_ack=1.
- Write len 3 @0x0104 -> cycle 1: cs_od/cs_ev, adrs_od=0x0104, adrs_ev=0x0108; cycle 2: cs_od only, adrs_od=0x010C; cmd_done cycle 3.
- Read len 4 @0x0100 after memory preloaded word i = 0xA0+i -> rd_vld cycles 3,4: (0xA0,0xA1),(0xA2,0xA3); cmd_done cycle 4.
- Read len 3 @0x0104 -> rd_dt (0xA1,0xA2) then (0xA3,0); swap correct for odd phase.
- Read len 2 @0xFFFC -> adrs_od=0xFFFC, adrs_ev=0x0000 (wrap); with BOUND_CHK_EN: no cs, cmd_done+cmd_err cycle 1.
- len 0 command then back-to-back write len 2 -> cmd_done cycle 1, second accepted cycle 1, its beat in cycle 2.
